ahb_lite_master: RTL and testbench

- Single-initiator AHB-Lite master. Converts a simple valid/ready command stream into AHB SINGLE transfers and returns one response per command.
- Sits between a local engine (DMA, test driver) and the AHB decoder/mux, in the same fabric as the default slave.
- Handles slave wait states, OKAY/ERROR responses, and the two-cycle ERROR response, including the sequence produced by the default slave for unmapped addresses.

---
 rtl/ahb_lite_master_pkg.sv | 31 +++
 rtl/ahb_lite_master.sv | 131 +++++++++++++
 tb/tb_ahb_lite_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings and the A-slot state type for ahb_lite_master.
// The optional overlap of address and data phases is enabled by AHB_MASTER_PIPELINE_EN.
`ifndef AHB_LITE_MASTER_PKG_SV
`define AHB_LITE_MASTER_PKG_SV

`define AHB_TRANS_BITS   2
`define AHB_RESP_BITS    1
`define AHB_TRANS_IDLE   2'b00
`define AHB_TRANS_NONSEQ 2'b10
`define AHB_TRANS_SEQ    2'b11
`define AHB_RESP_OKAY    1'b0
`define AHB_RESP_ERROR   1'b1
`define AHB_BURST_SINGLE 3'b000
`define AHB_SIZE_WORD    3'b010

package ahb_lite_master_pkg;

  // HELD: the command was cancelled by an ERROR and waits to be reissued.
  typedef enum logic [1:0] {
    A_EMPTY  = 2'd0,
    A_ACTIVE = 2'd1,
    A_HELD   = 2'd2
  } aslot_e;

  function automatic logic resp_is_err(input logic [`AHB_RESP_BITS-1:0] resp);
    return resp == `AHB_RESP_ERROR;
  endfunction

endpackage

`endif

// File: rtl/ahb_lite_master.sv
// Single-initiator AHB-Lite master: valid/ready commands in, SINGLE transfers out, one response each.
// Define AHB_MASTER_PIPELINE_EN to let an address phase overlap the previous data phase.
module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [2:0]                 cmd_size,
  input  logic [DATA_W-1:0]          cmd_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_err,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [ADDR_W-1:0]          HADDR,
  output logic [`AHB_TRANS_BITS-1:0] HTRANS,
  output logic                       HWRITE,
  output logic [2:0]                 HSIZE,
  output logic [2:0]                 HBURST,
  output logic [DATA_W-1:0]          HWDATA,
  input  logic                       HREADY,
  input  logic [`AHB_RESP_BITS-1:0]  HRESP,
  input  logic [DATA_W-1:0]          HRDATA
);

  aslot_e              a_state_p0;
  aslot_e              a_state_nxt;
  logic [DATA_W-1:0]   a_wdata_p0;
  logic                vld_p1;
  logic                d_write_p1;
  logic                a_active;
  logic                a_done;
  logic                d_done;
  logic                d_err;
  logic                cmd_fire;

  assign a_active = (a_state_p0 == A_ACTIVE);
  assign a_done   = a_active && HREADY;
  assign d_done   = vld_p1 && HREADY;
  assign d_err    = resp_is_err(HRESP);

`ifdef AHB_MASTER_PIPELINE_EN
  assign cmd_ready = HRESETn && ((a_state_p0 == A_EMPTY) || a_done);
`else
  assign cmd_ready = HRESETn && (a_state_p0 == A_EMPTY) && !vld_p1;
`endif

  assign cmd_fire = cmd_valid && cmd_ready;
  assign HTRANS   = a_active ? `AHB_TRANS_NONSEQ : `AHB_TRANS_IDLE;
  assign HBURST   = `AHB_BURST_SINGLE;

  always_comb begin
    a_state_nxt = a_state_p0;
    case (a_state_p0)
      A_EMPTY: begin
        if (cmd_fire) a_state_nxt = A_ACTIVE;
      end
      A_ACTIVE: begin
        if (a_done) begin
          a_state_nxt = cmd_fire ? A_ACTIVE : A_EMPTY;
        end
`ifdef AHB_MASTER_PIPELINE_EN
        else if (vld_p1 && d_err) begin
          a_state_nxt = A_HELD;
        end
`endif
      end
`ifdef AHB_MASTER_PIPELINE_EN
      A_HELD: begin
        if (d_done) a_state_nxt = A_ACTIVE;
      end
`endif
      default: a_state_nxt = A_EMPTY;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) a_state_p0 <= A_EMPTY;
    else          a_state_p0 <= a_state_nxt;
  end

  // p0: address-phase slot, loaded on accept
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR  <= '0;
      HWRITE <= 1'b0;
      HSIZE  <= 3'd0;
    end else if (cmd_fire) begin
      HADDR  <= cmd_addr;
      HWRITE <= cmd_write;
      HSIZE  <= cmd_size;
    end
  end

  always_ff @(posedge HCLK) begin
    if (cmd_fire) a_wdata_p0 <= cmd_wdata;
    if (a_done)   d_write_p1 <= HWRITE;
  end

  // p1: data-phase slot, filled when the address phase completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p1 <= 1'b0;
      HWDATA <= '0;
    end else if (a_done) begin
      vld_p1 <= 1'b1;
      HWDATA <= HWRITE ? a_wdata_p0 : '0;
    end else if (d_done) begin
      vld_p1 <= 1'b0;
    end
  end

  // p2: one-cycle response pulse
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= d_done;
      rsp_err   <= d_done && d_err;
      rsp_rdata <= (d_done && !d_err && !d_write_p1) ? HRDATA : '0;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master; the overlap scenarios follow AHB_MASTER_PIPELINE_EN.
module tb_ahb_lite_master;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;

  int tests  = 0;
  int failed = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, let combinational outputs settle before checks.
  task automatic drv(input logic v, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic rdy, input logic rsp, input logic [31:0] rd);
    @(negedge HCLK);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    HREADY = rdy; HRESP = rsp; HRDATA = rd;
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_size = 3'd2;
    HREADY = 1; HRESP = 0; HRDATA = 0;
    #1;
    chk("rst_htrans", HTRANS, T_IDLE);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("hburst_single", HBURST, 0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    // Zero-wait read
    drv(1, 0, 32'h10, 0, 1, 0, 0);
    chk("rd_ready", cmd_ready, 1);
    chk("rd_idle_pre", HTRANS, T_IDLE);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("rd_nonseq", HTRANS, T_NSEQ);
    chk("rd_haddr", HADDR, 32'h10);
    chk("rd_hwrite", HWRITE, 0);
    chk("rd_hsize", HSIZE, 3'd2);
    drv(0, 0, 0, 0, 1, 0, 32'hA5A5_0001);
    chk("rd_dphase_idle", HTRANS, T_IDLE);
    chk("rd_no_early_rsp", rsp_valid, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("rd_rsp_pulse", rsp_valid, 0);

    // Write with three wait states
    drv(1, 1, 32'h20, 32'hDEAD_BEEF, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("wr_nonseq", HTRANS, T_NSEQ);
    chk("wr_hwrite", HWRITE, 1);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0);
      chk("wr_wait_hwdata", HWDATA, 32'hDEAD_BEEF);
      chk("wr_wait_no_rsp", rsp_valid, 0);
    end
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("wr_last_hwdata", HWDATA, 32'hDEAD_BEEF);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("wr_rsp_pulse", rsp_valid, 0);

    // Unmapped read: default slave answers HREADY 1,0,1 with ERROR,ERROR
    drv(1, 0, 32'hF000_0000, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("err_nonseq", HTRANS, T_NSEQ);
    drv(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    chk("err_first_no_rsp", rsp_valid, 0);
    drv(0, 0, 0, 0, 1, 1, 32'h1234_5678);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("err_rsp_valid", rsp_valid, 1);
    chk("err_rsp_err", rsp_err, 1);
    chk("err_rsp_rdata", rsp_rdata, 0);

`ifdef AHB_MASTER_PIPELINE_EN
    // Four back-to-back zero-wait writes
    for (int k = 0; k < 7; k++) begin
      drv(k < 4, 1, 32'h100 + 32'(4 * k), 32'h5000 + 32'(k), 1, 0, 0);
      chk("b2b_htrans", HTRANS, (k >= 1 && k <= 4) ? T_NSEQ : T_IDLE);
      if (k >= 1 && k <= 4) chk("b2b_haddr", HADDR, 32'h100 + 32'(4 * (k - 1)));
      if (k >= 2 && k <= 5) chk("b2b_hwdata", HWDATA, 32'h5000 + 32'(k - 2));
      chk("b2b_rsp_valid", rsp_valid, k >= 3);
      if (k >= 3) chk("b2b_rsp_err", rsp_err, 0);
    end

    // Erroring write cancels the overlapped read, which is reissued afterwards
    drv(1, 1, 32'hF000_0000, 32'h11, 1, 0, 0);
    drv(1, 0, 32'h10, 0, 1, 0, 0);
    chk("cx_w_nonseq", HTRANS, T_NSEQ);
    chk("cx_rd_ready", cmd_ready, 1);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("cx_rd_nonseq", HTRANS, T_NSEQ);
    chk("cx_rd_haddr", HADDR, 32'h10);
    drv(0, 0, 0, 0, 1, 1, 0);
    chk("cx_cancel_idle", HTRANS, T_IDLE);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("cx_w_rsp_valid", rsp_valid, 1);
    chk("cx_w_rsp_err", rsp_err, 1);
    chk("cx_reissue", HTRANS, T_NSEQ);
    chk("cx_reissue_haddr", HADDR, 32'h10);
    drv(0, 0, 0, 0, 1, 0, 32'h5A);
    chk("cx_gap_rsp", rsp_valid, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("cx_rd_rsp_valid", rsp_valid, 1);
    chk("cx_rd_rsp_err", rsp_err, 0);
    chk("cx_rd_rsp_rdata", rsp_rdata, 32'h5A);
`else
    // Erroring write then read: no overlap, IDLE gap before the read
    drv(1, 1, 32'hF000_0000, 32'h11, 1, 0, 0);
    drv(1, 0, 32'h10, 0, 1, 0, 0);
    chk("seq_w_nonseq", HTRANS, T_NSEQ);
    chk("seq_busy_ready", cmd_ready, 0);
    drv(1, 0, 32'h10, 0, 0, 1, 0);
    chk("seq_err1_idle", HTRANS, T_IDLE);
    chk("seq_err1_ready", cmd_ready, 0);
    drv(1, 0, 32'h10, 0, 1, 1, 0);
    chk("seq_err2_ready", cmd_ready, 0);
    drv(1, 0, 32'h10, 0, 1, 0, 0);
    chk("seq_w_rsp_valid", rsp_valid, 1);
    chk("seq_w_rsp_err", rsp_err, 1);
    chk("seq_gap_idle", HTRANS, T_IDLE);
    chk("seq_rd_ready", cmd_ready, 1);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("seq_rd_nonseq", HTRANS, T_NSEQ);
    chk("seq_rd_haddr", HADDR, 32'h10);
    drv(0, 0, 0, 0, 1, 0, 32'h5A);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("seq_rd_rsp_valid", rsp_valid, 1);
    chk("seq_rd_rsp_err", rsp_err, 0);
    chk("seq_rd_rsp_rdata", rsp_rdata, 32'h5A);
`endif

    // Reset during a data phase
    drv(1, 1, 32'h40, 32'hCAFE_0001, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("rst_mid_nonseq", HTRANS, T_NSEQ);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_hwdata", HWDATA, 32'hCAFE_0001);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_mid_idle_async", HTRANS, T_IDLE);
    chk("rst_mid_ready", cmd_ready, 0);
    chk("rst_mid_hwdata_clr", HWDATA, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("rst_mid_no_rsp", rsp_valid, 0);
    HRESETn = 1'b1;
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("rst_after_no_rsp", rsp_valid, 0);
    chk("rst_after_idle", HTRANS, T_IDLE);

    // Clean restart
    drv(1, 0, 32'h10, 0, 1, 0, 0);
    chk("rs_ready", cmd_ready, 1);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("rs_nonseq", HTRANS, T_NSEQ);
    drv(0, 0, 0, 0, 1, 0, 32'h77);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("rs_rsp_valid", rsp_valid, 1);
    chk("rs_rsp_rdata", rsp_rdata, 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
